rca_instruction_generator: RTL

RCA_INSTRUCTION_GENERATOR -- requirements
Module: rca_instruction_generator

---
 rtl/rca_instruction_generator.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rca_instruction_generator.sv
// Expands one RCA command descriptor into cmd_count encoded custom-1 instruction words.
// Illegal descriptors are dropped with a single-cycle cmd_error pulse.
module rca_instruction_generator #(
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_op,
    input  logic [1:0]         cmd_rca_id,
    input  logic [4:0]         cmd_rd,
    input  logic [4:0]         cmd_rs1,
    input  logic [4:0]         cmd_rs2,
    input  logic [COUNT_W-1:0] cmd_count,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr,
    output logic               instr_last,
    output logic               cmd_error,
    output logic               busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and offered data stays stable until it is taken.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        REJECT = 2'd2
    } state_t;

    localparam logic [6:0] RCA_OPCODE = 7'b0101011;

    state_t state;
    state_t state_next;

    logic [3:0]         op_q;
    logic [1:0]         rca_id_q;
    logic [4:0]         rd_q;
    logic [4:0]         rs1_q;
    logic [4:0]         rs2_q;
    logic [COUNT_W-1:0] remain_q;

    logic cmd_accept;
    logic instr_fire;
    logic cmd_illegal;
    logic is_last;
    logic is_config;

    assign cmd_accept  = cmd_valid && cmd_ready;
    assign instr_fire  = instr_valid && instr_ready;
    assign cmd_illegal = (cmd_op > 4'd12) || (cmd_count == '0);
    assign is_last     = (remain_q == COUNT_W'(1));
    assign is_config   = (op_q >= 4'd2) && (op_q <= 4'd8);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    state_next = cmd_illegal ? REJECT : ISSUE;
                end
            end
            ISSUE: begin
                if (instr_fire && is_last) begin
                    state_next = IDLE;
                end
            end
            REJECT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Descriptor is captured once; the count only ever decrements so it cannot overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            rca_id_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            remain_q <= '0;
        end else if (cmd_accept) begin
            op_q     <= cmd_op;
            rca_id_q <= cmd_rca_id;
            rd_q     <= cmd_rd;
            rs1_q    <= cmd_rs1;
            rs2_q    <= cmd_rs2;
            remain_q <= cmd_count;
        end else if (instr_fire) begin
            remain_q <= remain_q - COUNT_W'(1);
            if (is_config) begin
                rs1_q <= rs1_q + 5'd1;
            end
        end
    end

    always_comb begin
        cmd_ready   = 1'b0;
        instr_valid = 1'b0;
        instr_last  = 1'b0;
        instr       = 32'h0;
        cmd_error   = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: cmd_ready = 1'b1;
            ISSUE: begin
                instr_valid = 1'b1;
                instr_last  = is_last;
                instr       = {3'b000, op_q, rs2_q, rs1_q, 1'b0, rca_id_q, rd_q, RCA_OPCODE};
            end
            REJECT:  cmd_error = 1'b1;
            default: ;
        endcase
    end

endmodule
